// File: rtl/basic_adder_unit.sv
// Execute-stage address/target adder: decodes the issued RV32I instruction, picks PC or rs1 plus the
// sign-extended immediate, and adds modulo 2^32. Also provides a registered copy of the sum with a valid flag.
// is_pack layout: [127:96] inst, [95:64] PC, [63:32] rs1_value, [31:0] rs2_value.
module basic_adder_unit (
   input  logic         clock,
   input  logic         reset,
   input  logic [127:0] is_pack,
   input  logic         valid_in,
   output logic [31:0]  result,
   output logic [31:0]  result_q,
   output logic         valid_q
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] rs1_value;
   logic [31:0] rs2_value;

   assign inst      = is_pack[127:96];
   assign pc        = is_pack[95:64];
   assign rs1_value = is_pack[63:32];
   assign rs2_value = is_pack[31:0];

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic [31:0] imm_u;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};

   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] sum;
   logic        clear_lsb;

   always_comb begin
      opa       = rs1_value;
      opb       = rs2_value;
      clear_lsb = 1'b0;
      case (inst[6:0])
         OP_BRANCH: begin opa = pc;        opb = imm_b; end
         OP_JAL:    begin opa = pc;        opb = imm_j; end
         OP_JALR:   begin opa = rs1_value; opb = imm_i; clear_lsb = 1'b1; end
         OP_LOAD:   begin opa = rs1_value; opb = imm_i; end
         OP_STORE:  begin opa = rs1_value; opb = imm_s; end
         OP_AUIPC:  begin opa = pc;        opb = imm_u; end
         OP_LUI:    begin opa = 32'd0;     opb = imm_u; end
         default:   begin opa = rs1_value; opb = rs2_value; end
      endcase
   end

   // Carry-out is intentionally dropped: targets wrap modulo 2^32.
   assign sum    = opa + opb;
   assign result = {sum[31:1], sum[0] & ~clear_lsb};

   logic [31:0] result_d;
   logic        valid_d;

   always_comb begin
      result_d = valid_in ? result : 32'd0;
      valid_d  = valid_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         result_q <= 32'd0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: tb/tb_basic_adder_unit.sv
// Self-checking bench for basic_adder_unit: directed RV32I cases plus randomized packets
// compared against an arithmetic reference model.
module tb_basic_adder_unit;

   logic         clock;
   logic         reset;
   logic [127:0] is_pack;
   logic         valid_in;
   logic [31:0]  result;
   logic [31:0]  result_q;
   logic         valid_q;

   int n_cmp = 0;
   int n_err = 0;

   basic_adder_unit dut (
      .clock    (clock),
      .reset    (reset),
      .is_pack  (is_pack),
      .valid_in (valid_in),
      .result   (result),
      .result_q (result_q),
      .valid_q  (valid_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: signed immediate as a plain integer, added to the base with 32-bit wrap.
   function automatic logic [31:0] model(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] rs1, input logic [31:0] rs2);
      int imm;
      logic [31:0] r;
      case (inst[6:0])
         7'b1100011: begin imm = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})); r = pc + imm; end
         7'b1101111: begin imm = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})); r = pc + imm; end
         7'b1100111: begin imm = int'($signed(inst[31:20])); r = rs1 + imm; r = r - (r % 2); end
         7'b0000011: begin imm = int'($signed(inst[31:20])); r = rs1 + imm; end
         7'b0100011: begin imm = int'($signed({inst[31:25], inst[11:7]})); r = rs1 + imm; end
         7'b0010111: r = pc + (inst & 32'hFFFF_F000);
         7'b0110111: r = inst & 32'hFFFF_F000;
         default:    r = rs1 + rs2;
      endcase
      return r;
   endfunction

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      is_pack = {inst, pc, rs1, rs2};
   endtask

   task automatic check_comb(input string name, input logic [31:0] exp);
      // combinational observation only; each caller supplies its own expected constant
      #1;
      n_cmp++;
      if (result !== exp) begin
         n_err++;
         $display("FAIL %s: result=%h expected=%h", name, result, exp);
      end else
         $display("ok   %s: result=%h", name, result);
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1; valid_in = 1'b1;
      drive(32'h00208463, 32'h1000, 32'h0, 32'h0);
      @(posedge clock); #1;
      n_cmp++;
      if (result_q !== 32'd0 || valid_q !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: result_q=%h valid_q=%b expected 0/0", result_q, valid_q);
      end else
         $display("ok   reset_state: result_q=%h valid_q=%b", result_q, valid_q);
      @(negedge clock);
      reset = 1'b0; valid_in = 1'b0;
   endtask

   task automatic test_branch();
      @(negedge clock);
      drive(32'h00208463, 32'h1000, 32'h1234_5678, 32'h9ABC_DEF0);
      check_comb("beq_fwd", 32'h1008);
      drive(32'h00208463, 32'h1000, 32'hFFFF_FFFF, 32'h0000_0001);
      check_comb("beq_rs_indep", 32'h1008);
      drive(32'hFE208EE3, 32'h1000, 32'h0, 32'h0);
      check_comb("branch_back", 32'h0FFC);
      drive(32'hFE208EE3, 32'h2, 32'h0, 32'h0);
      check_comb("branch_wrap", 32'hFFFF_FFFE);
   endtask

   task automatic test_jumps();
      @(negedge clock);
      drive({12'd2, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h0, 32'h2003, 32'h0);
      check_comb("jalr_lsb", 32'h2004);
      // J-imm = +0x800 sets only imm[11], which lives at inst[20]
      drive({1'b0, 10'd0, 1'b1, 8'd0, 5'd1, 7'b1101111}, 32'h100, 32'h0, 32'h0);
      check_comb("jal", 32'h900);
      drive({20'hABCDE, 5'd3, 7'b0010111}, 32'h0000_1000, 32'h0, 32'h0);
      check_comb("auipc", 32'hABCD_F000);
   endtask

   task automatic test_mem_lui();
      @(negedge clock);
      drive({12'hFFF, 5'd2, 3'b010, 5'd3, 7'b0000011}, 32'h0, 32'h8000, 32'h0);
      check_comb("load_neg", 32'h7FFF);
      drive({7'b0000001, 5'd2, 5'd1, 3'b010, 5'b00000, 7'b0100011}, 32'h0, 32'h10, 32'h0);
      check_comb("store", 32'h30);
      drive({20'h12345, 5'd4, 7'b0110111}, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0);
      check_comb("lui", 32'h1234_5000);
      drive({7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h0, 32'hFFFF_FFF0, 32'h20);
      check_comb("other_rs_add", 32'h10);
   endtask

   task automatic test_registered();
      @(negedge clock);
      drive(32'h00208463, 32'h1000, 32'h0, 32'h0);
      valid_in = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if (result_q !== 32'h1008 || valid_q !== 1'b1) begin
         n_err++;
         $display("FAIL reg_edge1: result_q=%h valid_q=%b expected 00001008/1", result_q, valid_q);
      end else
         $display("ok   reg_edge1: result_q=%h valid_q=%b", result_q, valid_q);
      @(negedge clock);
      valid_in = 1'b0;
      @(posedge clock); #1;
      n_cmp++;
      if (result_q !== 32'd0 || valid_q !== 1'b0) begin
         n_err++;
         $display("FAIL reg_edge2: result_q=%h valid_q=%b expected 0/0", result_q, valid_q);
      end else
         $display("ok   reg_edge2: result_q=%h valid_q=%b", result_q, valid_q);
   endtask

   task automatic test_reset_midstream();
      @(negedge clock);
      drive(32'h00208463, 32'h1000, 32'h0, 32'h0);
      valid_in = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if (result_q !== 32'd0 || valid_q !== 1'b0 || result !== 32'h1008) begin
         n_err++;
         $display("FAIL reset_mid: result_q=%h valid_q=%b result=%h expected 0/0/00001008",
                  result_q, valid_q, result);
      end else
         $display("ok   reset_mid: result_q=%h valid_q=%b result=%h", result_q, valid_q, result);
      @(negedge clock);
      reset = 1'b0; valid_in = 1'b0;
   endtask

   task automatic test_random();
      logic [6:0]  ops [8];
      logic [31:0] inst, pc, rs1, rs2, exp_c;
      logic [31:0] exp_rq;
      logic        exp_vq;
      logic        v, r;
      ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011,
              7'b0100011, 7'b0010111, 7'b0110111, 7'b0110011};
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         inst = $urandom;
         inst[6:0] = (($urandom % 9) == 8) ? 7'($urandom) : ops[$urandom % 8];
         pc = $urandom; rs1 = $urandom; rs2 = $urandom;
         v = 1'($urandom); r = (($urandom % 16) == 0);
         drive(inst, pc, rs1, rs2);
         valid_in = v; reset = r;
         exp_c  = model(inst, pc, rs1, rs2);
         exp_rq = (r || !v) ? 32'd0 : exp_c;
         exp_vq = !r && v;
         #1;
         n_cmp++;
         if (result !== exp_c) begin
            n_err++;
            $display("FAIL rand_comb[%0d]: inst=%h result=%h expected=%h", i, inst, result, exp_c);
         end else
            $display("ok   rand_comb[%0d]: inst=%h result=%h", i, inst, result);
         @(posedge clock); #1;
         n_cmp++;
         if (result_q !== exp_rq || valid_q !== exp_vq) begin
            n_err++;
            $display("FAIL rand_reg[%0d]: result_q=%h valid_q=%b expected %h/%b",
                     i, result_q, valid_q, exp_rq, exp_vq);
         end else
            $display("ok   rand_reg[%0d]: result_q=%h valid_q=%b", i, result_q, valid_q);
      end
      @(negedge clock);
      reset = 1'b0; valid_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; is_pack = '0;
      test_reset();
      test_branch();
      test_jumps();
      test_mem_lui();
      test_registered();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/basic_adder_unit.md
# basic_adder_unit

Combinational 32-bit address/target adder used inside execute-stage functional units; the branch FU uses it to form the taken-branch target. It decodes the instruction carried in the issue packet, selects the two addends (PC or rs1, plus the correctly sign-extended immediate), and adds them modulo 2^32. The sum is available in the same cycle, and a registered copy with a valid flag is provided for units that need a pipelined result.

## Interface
- No parameters. Widths come from `sys_defs.svh` (`ADDR` = 32 bits, `DATA` = 32 bits).
- clock  in  1  system clock; only the registered outputs use it.
- reset  in  1  synchronous, active-high.
- is_pack  in  ISSUE_PACKET  issue packet. Fields used:
  - decoded_vals.decoded_vals.inst: 32-bit RISC-V instruction.
  - decoded_vals.decoded_vals.PC: instruction address.
  - rs1_value, rs2_value: 32-bit operands.
- valid_in  in  1  packet is live this cycle; qualifies the registered path only.
- result  out  ADDR(32)  combinational sum for the current is_pack.
- result_q  out  ADDR(32)  result registered on the clock edge.
- valid_q  out  1  registered valid_in.

## Operation
- The opcode is inst[6:0]. Immediates follow the RISC-V RV32I formats, all sign-extended from inst[31]:
  - I-imm = {inst[31:20]}
  - S-imm = {inst[31:25], inst[11:7]}
  - B-imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - J-imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - U-imm = {inst[31:12], 12'b0}
- Operand selection by opcode:
  - 1100011 (BRANCH, any funct3): PC + B-imm.
  - 1101111 (JAL): PC + J-imm.
  - 1100111 (JALR): (rs1_value + I-imm) with bit 0 forced to 0.
  - 0000011 (LOAD): rs1_value + I-imm.
  - 0100011 (STORE): rs1_value + S-imm.
  - 0010111 (AUIPC): PC + U-imm.
  - 0110111 (LUI): 0 + U-imm.
  - any other opcode: rs1_value + rs2_value.
- Arithmetic is unsigned 32-bit addition; the carry-out is discarded, so results wrap modulo 2^32.
- No flags, no overflow detection, and no exceptions for misaligned targets.
- result depends only on is_pack. It ignores valid_in, clock and reset.

## Timing
- result: zero latency (purely combinational), so the branch FU can register the target in the same cycle the packet is issued.
- Registered path, on each posedge:
  - reset=1: result_q <= 0, valid_q <= 0.
  - otherwise: result_q <= result if valid_in, else 0; valid_q <= valid_in.
- Reset values: result_q = 0, valid_q = 0. result has no reset value; it tracks is_pack.
- Reset asserted mid-stream clears the registered outputs on the next edge; a packet presented in that cycle is dropped from the registered path.
- There is no handshake and no stall; a new packet can be accepted every cycle.

## Test plan
- BEQ, PC=0x1000, B-imm=+8 (inst 0x00208463): result=0x1008 in the same cycle, independent of the rs values.
- Backward branch, PC=0x1000, B-imm=-4 (inst 0xFE208EE3): result=0x0FFC. Then PC=0x2, B-imm=-4: result=0xFFFFFFFE (wraps).
- JALR, rs1=0x2003, I-imm=+2: result=0x2004 (bit 0 cleared). JAL, PC=0x100, J-imm=+0x800: result=0x900.
- LOAD, rs1=0x8000, imm=-1: result=0x7FFF. STORE, rs1=0x10, S-imm=+0x20: result=0x30. LUI 0x12345: result=0x12345000.
- Registered path: valid_in=1 with a packet yielding 0x1008, then valid_in=0. Expect result_q=0x1008 and valid_q=1 after edge 1; result_q=0 and valid_q=0 after edge 2.
- Assert reset while valid_in=1: after the edge, result_q=0 and valid_q=0, while result still equals the combinational sum.
